// File: rtl/gpu_stream_pkg.sv
// Shared definitions for the GPU stream adapters: the FIFO reader state
// encoding and the beats-per-word helper.
package gpu_stream_pkg;

   typedef enum logic {
      RD_IDLE,
      RD_HOLD
   } rd_state_t;

   // Number of OW-bit beats carried by one IW-bit word.
   function automatic int beats_f(input int iw, input int ow);
      return iw / ow;
   endfunction

endpackage

// File: rtl/fifo_unpack_reader.sv
// Drain side of a synchronous FIFO: pops IW-bit words and replays each one as
// IW/OW beats of OW bits on a valid/ready stream, least-significant beat first.
//
// Handshake: a beat transfers on every rising edge where o_valid & i_ready.
// o_valid/o_data/o_last are stable while o_valid & !i_ready. o_valid never
// depends on i_ready. The FIFO side pops on every edge where o_fifo_rd is high,
// and o_fifo_rd is only raised while i_fifo_empty is low.
module fifo_unpack_reader
   import gpu_stream_pkg::*;
#(
   parameter int IW = 64,
   parameter int OW = 16
) (
   input  logic          i_clk,
   input  logic          i_resetn,
   input  logic          i_fifo_empty,
   input  logic [IW-1:0] i_fifo_data,
   output logic          o_fifo_rd,
   input  logic          i_flush,
   output logic          o_valid,
   output logic [OW-1:0] o_data,
   output logic          o_last,
   input  logic          i_ready,
   output logic          o_busy,
   output rd_state_t     o_state
);

   localparam int BEATS = beats_f(IW, OW);
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   // A word must split into a whole number of beats.
   if ((IW % OW) != 0 || OW > IW) begin : g_width_check
      $error("fifo_unpack_reader: IW must be a non-zero multiple of OW");
   end

   rd_state_t         state;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     word_q;
   logic              held;
   logic              beat_last;
   logic              fire;

   assign held      = (state == RD_HOLD);
   assign beat_last = (cnt == CW'(BEATS - 1));
   assign fire      = held & i_ready;

   // Pop when nothing is held, or when the final beat of the held word leaves
   // this cycle, so back-to-back words stream without a bubble.
   assign o_fifo_rd = i_resetn & ~i_fifo_empty & ~i_flush &
                      (~held | (fire & beat_last));

   assign o_valid = held;
   assign o_busy  = held;
   assign o_last  = held & beat_last;
   assign o_data  = word_q[int'(cnt) * OW +: OW];
   assign o_state = state;

   // Reader FSM: load on pop, step the beat counter on each fire, flush drops the word.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state  <= RD_IDLE;
         cnt    <= '0;
         word_q <= '0;
      end else if (i_flush) begin
         state <= RD_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            RD_IDLE: begin
               if (o_fifo_rd) begin
                  word_q <= i_fifo_data;
                  cnt    <= '0;
                  state  <= RD_HOLD;
               end
            end
            RD_HOLD: begin
               if (fire) begin
                  if (!beat_last) begin
                     cnt <= cnt + CW'(1);
                  end else if (o_fifo_rd) begin
                     word_q <= i_fifo_data;
                     cnt    <= '0;
                  end else begin
                     cnt   <= '0;
                     state <= RD_IDLE;
                  end
               end
            end
            default: begin
               state <= RD_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
